if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 126 ++++++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with a
// single-entry hold buffer, redirect (se) with kill of the in-flight response.
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        se,
  input  logic [63:0] pc_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg;
  logic        kill_reg, kill_next;
  logic        if_valid_reg;
  logic [63:0] if_pc_reg;
  logic [31:0] if_instr_reg;
  logic [63:0] hold_pc_reg;
  logic [31:0] hold_instr_reg;

  logic handshake, redirect, if_free, resp_take, load_new, to_hold;

  assign handshake = (state_reg == REQ) && imem_req_ready;
  assign redirect  = se && (state_reg != IDLE);
  assign if_free   = !if_valid_reg || id_ready;
  assign resp_take = (state_reg == WAIT) && imem_resp_valid && !kill_reg && !se;
  assign load_new  = (resp_take && if_free) || ((state_reg == HOLD) && id_ready && !se);
  assign to_hold   = resp_take && !if_free;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (handshake) begin
          state_next = WAIT;
          kill_next  = se;
        end
      end
      WAIT: begin
        // A response always retires the outstanding request, killed or not.
        if (imem_resp_valid) begin
          kill_next = 1'b0;
          if (kill_reg || se || if_free) state_next = REQ;
          else                           state_next = HOLD;
        end else if (se) begin
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (se || id_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req_valid = (state_reg == REQ);
    imem_addr      = pc_reg;
    if_valid       = if_valid_reg;
    if_pc          = if_pc_reg;
    if_instr       = if_instr_reg;
  end

  // Datapath: pc, IF/ID and hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= 64'h0;
      if_instr_reg   <= NOP_INSTR;
      hold_pc_reg    <= 64'h0;
      hold_instr_reg <= 32'h0;
    end else if (redirect) begin
      pc_reg       <= {pc_target[63:2], 2'b00};
      if_valid_reg <= 1'b0;
      if_instr_reg <= NOP_INSTR;
    end else if (load_new) begin
      pc_reg       <= pc_reg + 64'd4;
      if_valid_reg <= 1'b1;
      if (state_reg == HOLD) begin
        if_pc_reg    <= hold_pc_reg;
        if_instr_reg <= hold_instr_reg;
      end else begin
        if_pc_reg    <= pc_reg;
        if_instr_reg <= imem_rdata;
      end
    end else begin
      if (to_hold) begin
        hold_pc_reg    <= pc_reg;
        hold_instr_reg <= imem_rdata;
      end
      if (id_ready) begin
        if_valid_reg <= 1'b0;
        if_instr_reg <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: handshake/capture, stall with hold, redirects,
// kill of in-flight responses, reset mid-fetch and pc wrap.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        se;
  logic [63:0] pc_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .se             (se),
    .pc_target      (pc_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; se = 1'b0; pc_target = 64'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    step(); step();
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_if_valid",  {63'h0, if_valid}, 64'h0);
    chk("rst_if_pc",     if_pc, 64'h0);
    chk("rst_if_instr",  {32'h0, if_instr}, {32'h0, NOP});
    chk("rst_addr",      imem_addr, 64'h0);

    // Basic fetch
    rst_n = 1'b1;
    step();
    chk("req0_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("req0_addr",  imem_addr, 64'h0);
    imem_req_ready = 1'b1;
    step();
    chk("wait0_valid", {63'h0, imem_req_valid}, 64'h0);
    imem_resp_valid = 1'b1; imem_rdata = 32'h00A00093; id_ready = 1'b1;
    step();
    imem_resp_valid = 1'b0;
    chk("cap0_if_valid", {63'h0, if_valid}, 64'h1);
    chk("cap0_if_pc",    if_pc, 64'h0);
    chk("cap0_if_instr", {32'h0, if_instr}, 64'h00A00093);
    chk("cap0_next_addr", imem_addr, 64'h4);
    chk("cap0_req_valid", {63'h0, imem_req_valid}, 64'h1);
    step();
    chk("consume_valid", {63'h0, if_valid}, 64'h0);
    chk("consume_instr", {32'h0, if_instr}, {32'h0, NOP});

    // Stall: two responses while id_ready=0
    id_ready = 1'b0; imem_resp_valid = 1'b1; imem_rdata = 32'h00100113;
    step();
    imem_resp_valid = 1'b0;
    chk("st_i1_pc",    if_pc, 64'h4);
    chk("st_i1_instr", {32'h0, if_instr}, 64'h00100113);
    chk("st_addr8",    imem_addr, 64'h8);
    step();
    imem_resp_valid = 1'b1; imem_rdata = 32'h00200193;
    step();
    imem_resp_valid = 1'b0;
    chk("hold_req0",   {63'h0, imem_req_valid}, 64'h0);
    chk("hold_instr",  {32'h0, if_instr}, 64'h00100113);
    step();
    chk("hold_req1",   {63'h0, imem_req_valid}, 64'h0);
    step();
    chk("hold_req2",   {63'h0, imem_req_valid}, 64'h0);
    chk("hold_if_pc",  if_pc, 64'h4);
    id_ready = 1'b1;
    step();
    chk("rel_valid", {63'h0, if_valid}, 64'h1);
    chk("rel_pc",    if_pc, 64'h8);
    chk("rel_instr", {32'h0, if_instr}, 64'h00200193);
    chk("rel_addr",  imem_addr, 64'hC);
    chk("rel_req",   {63'h0, imem_req_valid}, 64'h1);

    // Redirect during WAIT, stale response next cycle
    step();
    se = 1'b1; pc_target = 64'h100;
    step();
    se = 1'b0;
    chk("sew_req",   {63'h0, imem_req_valid}, 64'h0);
    chk("sew_valid", {63'h0, if_valid}, 64'h0);
    imem_resp_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("stale_valid", {63'h0, if_valid}, 64'h0);
    chk("stale_instr", {32'h0, if_instr}, {32'h0, NOP});
    chk("stale_addr",  imem_addr, 64'h100);
    chk("stale_req",   {63'h0, imem_req_valid}, 64'h1);

    // Redirect coincident with handshake
    se = 1'b1; pc_target = 64'h203;
    step();
    se = 1'b0;
    chk("seh_req",  {63'h0, imem_req_valid}, 64'h0);
    chk("seh_addr", imem_addr, 64'h200);
    imem_resp_valid = 1'b1; imem_rdata = 32'hBADC0DE0;
    step();
    imem_resp_valid = 1'b0;
    chk("kill_valid", {63'h0, if_valid}, 64'h0);
    chk("kill_addr",  imem_addr, 64'h200);
    chk("kill_req",   {63'h0, imem_req_valid}, 64'h1);

    // Reset during WAIT, response arriving while in reset
    step();
    chk("prerst_req", {63'h0, imem_req_valid}, 64'h0);
    rst_n = 1'b0; imem_resp_valid = 1'b1; imem_rdata = 32'h12345678;
    #2;
    chk("mrst_addr",   imem_addr, 64'h0);
    chk("mrst_if_pc",  if_pc, 64'h0);
    chk("mrst_req",    {63'h0, imem_req_valid}, 64'h0);
    step();
    chk("mrst_valid",  {63'h0, if_valid}, 64'h0);
    chk("mrst_instr",  {32'h0, if_instr}, {32'h0, NOP});
    rst_n = 1'b1; imem_resp_valid = 1'b0;
    step();
    chk("post_req",   {63'h0, imem_req_valid}, 64'h1);
    chk("post_addr",  imem_addr, 64'h0);
    chk("post_valid", {63'h0, if_valid}, 64'h0);

    // Redirect in REQ without handshake, then wrap at top of address space
    imem_req_ready = 1'b0; se = 1'b1; pc_target = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    se = 1'b0;
    chk("ser_req",  {63'h0, imem_req_valid}, 64'h1);
    chk("ser_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    imem_resp_valid = 1'b1; imem_rdata = 32'h00000033;
    step();
    imem_resp_valid = 1'b0;
    chk("wrap_pc",    if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", {32'h0, if_instr}, 64'h00000033);
    chk("wrap_addr",  imem_addr, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
